// File: rtl/registro_etapa_skid_pkg.sv
// Shared pipeline-control constants: handshake state encodings and their decode.
// out_valid is state[0] and in_ready is ~state[1], so other control blocks can reuse them.
package registro_etapa_skid_pkg;

  localparam int LEVEL_W = 2;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b11
  } state_t;

  function automatic logic [LEVEL_W-1:0] state_level(input state_t st);
    case (st)
      ST_ONE:  return 2'd1;
      ST_FULL: return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/registro_param.sv
// Width-parametrised register with synchronous reset to a fixed value and a load enable.
module registro_param #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= RESET_VALUE;
    end else if (enable) begin
      r_q <= d;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/registro_etapa_skid.sv
// Pipeline-stage register with valid/ready handshake, one-entry skid buffer and flush.
// Outputs decode from the state register only, so in_ready never depends on out_ready combinationally.
module registro_etapa_skid
  import registro_etapa_skid_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [LEVEL_W-1:0] level
);

  state_t           r_state;
  state_t           r_state_next;
  logic             w_acc;
  logic             w_pop;
  logic             w_main_en;
  logic             w_skid_en;
  logic [WIDTH-1:0] w_main_d;
  logic [WIDTH-1:0] w_skid_q;

  assign w_acc = in_valid & in_ready;
  assign w_pop = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= r_state_next;
    end
  end

  // Flush only touches the state; data registers keep their (now invalid) contents.
  always_comb begin
    r_state_next = r_state;
    w_main_en    = 1'b0;
    w_skid_en    = 1'b0;
    w_main_d     = in_data;
    if (!flush) begin
      case (r_state)
        ST_EMPTY: begin
          if (w_acc) begin
            r_state_next = ST_ONE;
            w_main_en    = 1'b1;
          end
        end
        ST_ONE: begin
          if (w_acc && w_pop) begin
            w_main_en = 1'b1;
          end else if (w_acc) begin
            r_state_next = ST_FULL;
            w_skid_en    = 1'b1;
          end else if (w_pop) begin
            r_state_next = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (w_pop) begin
            r_state_next = ST_ONE;
            w_main_en    = 1'b1;
            w_main_d     = w_skid_q;
          end
        end
        default: r_state_next = ST_EMPTY;
      endcase
    end else begin
      r_state_next = ST_EMPTY;
    end
  end

  always_comb begin
    out_valid = r_state[0];
    in_ready  = ~r_state[1];
    level     = state_level(r_state);
  end

  registro_param #(
    .WIDTH      (WIDTH),
    .RESET_VALUE(RESET_VALUE)
  ) u_main (
    .clk   (clk),
    .reset (reset),
    .enable(w_main_en),
    .d     (w_main_d),
    .q     (out_data)
  );

  registro_param #(
    .WIDTH      (WIDTH),
    .RESET_VALUE(RESET_VALUE)
  ) u_skid (
    .clk   (clk),
    .reset (reset),
    .enable(w_skid_en),
    .d     (in_data),
    .q     (w_skid_q)
  );

endmodule

// File: tb/tb_registro_etapa_skid.sv
// Bench for registro_etapa_skid: directed scenarios plus random traffic against a queue model.
module tb_registro_etapa_skid;

  localparam int          WIDTH = 32;
  localparam logic [31:0] RV    = 32'hDEAD_BEEF;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [WIDTH-1:0]  in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [WIDTH-1:0]  out_data;
  logic [1:0]        level;

  int checks = 0;
  int errors = 0;

  // Reference model: the stage is a FIFO of capacity two.
  logic [WIDTH-1:0] model_q[$];

  always #5 clk = ~clk;

  registro_etapa_skid #(
    .WIDTH      (WIDTH),
    .RESET_VALUE(RV)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .level    (level)
  );

  // Advance one clock, updating the model from the inputs presented during the cycle.
  task automatic tick();
    bit acc;
    bit pop;
    logic [WIDTH-1:0] d;
    acc = in_valid && (model_q.size() < 2);
    pop = out_ready && (model_q.size() > 0);
    d   = in_data;
    @(posedge clk);
    if (reset) begin
      model_q.delete();
    end else begin
      if (pop) void'(model_q.pop_front());
      if (flush) model_q.delete();
      else if (acc) model_q.push_back(d);
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks += 4;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    if (level !== 2'd0)     begin errors++; $display("FAIL reset_level got %0d want 0", level); end
    if (out_data !== RV)    begin errors++; $display("FAIL reset_out_data got %h want %h", out_data, RV); end
    $display("reset: out_valid=%b in_ready=%b level=%0d out_data=%h", out_valid, in_ready, level, out_data);
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1;
      in_data  = i;
      tick();
      checks += 3;
      if (out_data !== WIDTH'(i)) begin errors++; $display("FAIL stream_data got %h want %h", out_data, i); end
      if (out_valid !== 1'b1)     begin errors++; $display("FAIL stream_valid got %b want 1", out_valid); end
      if (level !== 2'd1)         begin errors++; $display("FAIL stream_level got %0d want 1", level); end
      $display("stream: beat %0d out_data=%h level=%0d", i, out_data, level);
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (level !== 2'd0) begin errors++; $display("FAIL stream_drain_level got %0d want 0", level); end
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hA; tick();
    in_data = 32'hB; tick();
    in_valid = 1'b0;
    checks += 3;
    if (level !== 2'd2)       begin errors++; $display("FAIL bp_level got %0d want 2", level); end
    if (in_ready !== 1'b0)    begin errors++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
    if (out_data !== 32'hA)   begin errors++; $display("FAIL bp_hold got %h want a", out_data); end
    tick();
    checks++;
    if (out_data !== 32'hA)   begin errors++; $display("FAIL bp_hold2 got %h want a", out_data); end
    out_ready = 1'b1;
    tick();
    checks += 3;
    if (out_data !== 32'hB)   begin errors++; $display("FAIL bp_pop2 got %h want b", out_data); end
    if (in_ready !== 1'b1)    begin errors++; $display("FAIL bp_ready_after_pop got %b want 1", in_ready); end
    if (level !== 2'd1)       begin errors++; $display("FAIL bp_level1 got %0d want 1", level); end
    tick();
    checks += 2;
    if (level !== 2'd0)       begin errors++; $display("FAIL bp_level0 got %0d want 0", level); end
    if (out_valid !== 1'b0)   begin errors++; $display("FAIL bp_empty_valid got %b want 0", out_valid); end
    out_ready = 1'b0;
    $display("backpressure: drained level=%0d", level);
  endtask

  task automatic test_flush();
    in_valid = 1'b1; in_data = 32'h1; tick();
    in_data = 32'h2; tick();
    flush = 1'b1; in_data = 32'h77; tick();
    flush = 1'b0; in_valid = 1'b0;
    checks += 3;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b want 0", out_valid); end
    if (level !== 2'd0)     begin errors++; $display("FAIL flush_level got %0d want 0", level); end
    if (in_ready !== 1'b1)  begin errors++; $display("FAIL flush_in_ready got %b want 1", in_ready); end
    in_valid = 1'b1; in_data = 32'h5; tick();
    in_valid = 1'b0;
    checks += 2;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL flush_next_valid got %b want 1", out_valid); end
    if (out_data !== 32'h5) begin errors++; $display("FAIL flush_next_data got %h want 5", out_data); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    $display("flush: post-flush beat 5 seen, level=%0d", level);
  endtask

  task automatic test_simultaneous();
    in_valid = 1'b1; in_data = 32'h10; tick();
    checks++;
    if (out_data !== 32'h10) begin errors++; $display("FAIL simul_first got %h want 10", out_data); end
    in_data = 32'h11; out_ready = 1'b1; tick();
    in_valid = 1'b0;
    checks += 3;
    if (out_data !== 32'h11) begin errors++; $display("FAIL simul_data got %h want 11", out_data); end
    if (level !== 2'd1)      begin errors++; $display("FAIL simul_level got %0d want 1", level); end
    if (in_ready !== 1'b1)   begin errors++; $display("FAIL simul_in_ready got %b want 1", in_ready); end
    tick(); out_ready = 1'b0;
    $display("simultaneous: out_data=%h level=%0d", out_data, level);
  endtask

  task automatic test_reset_over_flush();
    in_valid = 1'b1; in_data = 32'h21; tick();
    in_data = 32'h22; tick();
    reset = 1'b1; flush = 1'b1; tick();
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
    checks += 3;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rstflush_valid got %b want 0", out_valid); end
    if (level !== 2'd0)     begin errors++; $display("FAIL rstflush_level got %0d want 0", level); end
    if (out_data !== RV)    begin errors++; $display("FAIL rstflush_data got %h want %h", out_data, RV); end
    $display("reset_over_flush: out_data=%h level=%0d", out_data, level);
  endtask

  task automatic test_random();
    int pops = 0;
    int bad = 0;
    logic             held;
    logic [WIDTH-1:0] prev_data;
    for (int c = 0; c < 10000; c++) begin
      in_valid  = ($urandom_range(0, 99) < 60);
      out_ready = ($urandom_range(0, 99) < 55);
      flush     = ($urandom_range(0, 63) == 0);
      in_data   = $urandom;
      checks += 3;
      if (out_valid !== (model_q.size() > 0)) begin bad++; errors++; $display("FAIL rnd_valid cyc %0d got %b want %b", c, out_valid, model_q.size() > 0); end
      if (in_ready !== (model_q.size() < 2))  begin bad++; errors++; $display("FAIL rnd_in_ready cyc %0d got %b want %b", c, in_ready, model_q.size() < 2); end
      if (level !== 2'(model_q.size()))       begin bad++; errors++; $display("FAIL rnd_level cyc %0d got %0d want %0d", c, level, model_q.size()); end
      if (model_q.size() > 0) begin
        checks++;
        if (out_data !== model_q[0]) begin bad++; errors++; $display("FAIL rnd_data cyc %0d got %h want %h", c, out_data, model_q[0]); end
        if (out_ready) pops++;
      end
      held      = out_valid && !out_ready;
      prev_data = out_data;
      tick();
      if (held && !flush) begin
        checks += 2;
        if (out_data !== prev_data) begin bad++; errors++; $display("FAIL rnd_stable_data cyc %0d got %h want %h", c, out_data, prev_data); end
        if (out_valid !== 1'b1)     begin bad++; errors++; $display("FAIL rnd_stable_valid cyc %0d got %b want 1", c, out_valid); end
      end
    end
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    $display("random: 10000 cycles, %0d pops, %0d discrepancies", pops, bad);
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_simultaneous();
    test_reset_over_flush();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
